// File: rtl/bus_cycle_arbiter_if.sv
// System-bus side of bus_cycle_arbiter: strobes, qualifier and address toward memory/I/O slaves.
// DATA is a plain inout port on the arbiter because it is a resolved tri-state net.
interface bus_cycle_arbiter_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  ALE;
  logic                  RD_N;
  logic                  WR_N;
  logic                  M_IO;
  logic                  BUSY;
  logic [ADDR_WIDTH-1:0] ADDRESS;

  modport master (output ALE, RD_N, WR_N, M_IO, BUSY, ADDRESS);
  modport slave  (input  ALE, RD_N, WR_N, M_IO, BUSY, ADDRESS);
endinterface

// File: rtl/bus_cycle_arbiter.sv
// Two-requester 8088-style bus master: arbitrates A/B and runs zero-wait T1-T4 bus cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (A wins).
module bus_cycle_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_A,
  input  logic                  REQ_B,
  input  logic                  WR_A,
  input  logic                  WR_B,
  input  logic                  MIO_A,
  input  logic                  MIO_B,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  input  logic [DATA_WIDTH-1:0] WDATA_A,
  input  logic [DATA_WIDTH-1:0] WDATA_B,
  output logic                  ACK_A,
  output logic                  ACK_B,
  output logic [DATA_WIDTH-1:0] RDATA,
  inout  wire  [DATA_WIDTH-1:0] DATA,
  bus_cycle_arbiter_if.master   sys_bus
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  state_t                state, next_state;
  logic                  grant, grant_b, pick_b, handoff;
  logic                  owner_b, wr_q, mio_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                  busy, ale, rd_n, wr_n, drive_data, ack_a, ack_b;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_b;

  always_ff @(posedge CLK) begin
    if (RESET)
      last_b <= 1'b1;
    else if (grant)
      last_b <= grant_b;
  end

  assign pick_b  = REQ_B && (!REQ_A || !last_b);
  assign handoff = owner_b ? REQ_A : REQ_B;
`else
  // A finishing A cycle always drops to IDLE, where A wins again; only B hands over directly.
  assign pick_b  = REQ_B && !REQ_A;
  assign handoff = owner_b && REQ_A;
`endif

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          grant      = 1'b1;
          grant_b    = pick_b;
          next_state = T1;
        end
      end
      T1: next_state = T2;
      T2: next_state = T3;
      T3: next_state = T4;
      T4: begin
        next_state = IDLE;
        if (handoff) begin
          grant      = 1'b1;
          grant_b    = !owner_b;
          next_state = T1;
        end
      end
      default: next_state = IDLE;
    endcase

    busy       = (state != IDLE);
    ale        = (state == T1);
    rd_n       = !((state == T2 || state == T3) && !wr_q);
    wr_n       = !((state == T2 || state == T3) && wr_q);
    drive_data = wr_q && (state == T2 || state == T3 || state == T4);
    ack_a      = (state == T4) && !owner_b;
    ack_b      = (state == T4) && owner_b;
  end

  // Transfer registers load on every grant; RDATA samples the slave on the edge ending T3.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_b <= 1'b0;
      wr_q    <= 1'b0;
      mio_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_b <= grant_b;
        wr_q    <= grant_b ? WR_B    : WR_A;
        mio_q   <= grant_b ? MIO_B   : MIO_A;
        addr_q  <= grant_b ? ADDR_B  : ADDR_A;
        wdata_q <= grant_b ? WDATA_B : WDATA_A;
      end
      if (state == T3 && !wr_q)
        rdata_q <= DATA;
    end
  end

  assign sys_bus.ALE     = ale;
  assign sys_bus.RD_N    = rd_n;
  assign sys_bus.WR_N    = wr_n;
  assign sys_bus.M_IO    = busy && mio_q;
  assign sys_bus.BUSY    = busy;
  assign sys_bus.ADDRESS = busy ? addr_q : '0;
  assign ACK_A           = ack_a;
  assign ACK_B           = ack_b;
  assign RDATA           = rdata_q;
  assign DATA            = drive_data ? wdata_q : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Bench for bus_cycle_arbiter: zero-wait memory/I/O slave model, vector table and ACK scoreboard.
// Follows the ARB_ROUND_ROBIN_EN build option of the design for the simultaneous-request case.
module tb_bus_cycle_arbiter;
  localparam int AW = 20;
  localparam int DW = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic          side_b;
    logic          wr;
    logic          mio;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic          is_b;
    logic          is_read;
    logic [DW-1:0] rdata;
  } sb_t;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          req_a, req_b, wr_a, wr_b, mio_a, mio_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          ack_a, ack_b;
  logic [DW-1:0] rdata;
  wire  [DW-1:0] data_bus;

  logic [DW-1:0] mem_m  [0:255];
  logic [DW-1:0] mem_io [0:255];
  logic [7:0]    lat_addr;
  logic          lat_mio, rd_seen, wr_seen, slave_drive;
  logic [DW-1:0] slave_val;
  logic          probe_en;
  logic [DW-1:0] probe_val;

  sb_t  sb_q[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  bus_cycle_arbiter_if #(.ADDR_WIDTH(AW)) sys_bus ();

  bus_cycle_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .REQ_A   (req_a),
    .REQ_B   (req_b),
    .WR_A    (wr_a),
    .WR_B    (wr_b),
    .MIO_A   (mio_a),
    .MIO_B   (mio_b),
    .ADDR_A  (addr_a),
    .ADDR_B  (addr_b),
    .WDATA_A (wdata_a),
    .WDATA_B (wdata_b),
    .ACK_A   (ack_a),
    .ACK_B   (ack_b),
    .RDATA   (rdata),
    .DATA    (data_bus),
    .sys_bus (sys_bus)
  );

  assign data_bus = slave_drive ? slave_val : (probe_en ? probe_val : {DW{1'bz}});

  // Zero-wait slave: latch address on ALE, drive read data in T3, store write data at end of T3.
  always @(posedge CLK) begin
    if (RESET) begin
      rd_seen     <= 1'b0;
      wr_seen     <= 1'b0;
      slave_drive <= 1'b0;
    end else begin
      if (sys_bus.ALE) begin
        lat_addr <= sys_bus.ADDRESS[7:0];
        lat_mio  <= sys_bus.M_IO;
      end
      if (!sys_bus.RD_N) begin
        rd_seen     <= !rd_seen;
        slave_drive <= !rd_seen;
        slave_val   <= lat_mio ? mem_m[lat_addr] : mem_io[lat_addr];
      end else begin
        rd_seen     <= 1'b0;
        slave_drive <= 1'b0;
      end
      if (!sys_bus.WR_N) begin
        wr_seen <= !wr_seen;
        if (wr_seen) begin
          if (lat_mio) mem_m[lat_addr]  <= data_bus;
          else         mem_io[lat_addr] <= data_bus;
        end
      end else begin
        wr_seen <= 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] busWord();
    return {5'b0, sys_bus.ALE, sys_bus.RD_N, sys_bus.WR_N, sys_bus.M_IO, sys_bus.BUSY,
            ack_a, ack_b, sys_bus.ADDRESS};
  endfunction

  function automatic logic [31:0] expWord(input logic ale, input logic rd_n, input logic wr_n,
                                          input logic mio, input logic busy, input logic aa,
                                          input logic ab, input logic [AW-1:0] addr);
    return {5'b0, ale, rd_n, wr_n, mio, busy, aa, ab, addr};
  endfunction

  // One clock; outputs are sampled on the falling edge and any ACK retires a scoreboard entry.
  task automatic tick();
    sb_t e;
    @(posedge CLK);
    @(negedge CLK);
    if (ack_a || ack_b) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected_ack: got ack_a=%0b ack_b=%0b, expected none", ack_a, ack_b);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_owner", {30'b0, ack_a, ack_b}, {30'b0, !e.is_b, e.is_b});
        if (e.is_read) checkOutput("sb_rdata", {24'b0, rdata}, {24'b0, e.rdata});
      end
    end
  endtask

  task automatic setReq(input vec_t v, input logic req);
    if (v.side_b) begin
      wr_b = v.wr; mio_b = v.mio; addr_b = v.addr; wdata_b = v.wdata; req_b = req;
    end else begin
      wr_a = v.wr; mio_a = v.mio; addr_a = v.addr; wdata_a = v.wdata; req_a = req;
    end
  endtask

  // Single isolated transfer with per-cycle strobe checks, then one IDLE cycle.
  task automatic applyStimulus(input vec_t v);
    logic s;
    setReq(v, 1'b1);
    sb_q.push_back('{v.side_b, !v.wr, v.exp_rdata});
    for (int c = 1; c <= 4; c++) begin
      tick();
      s = (c == 2 || c == 3);
      checkOutput($sformatf("cycle_T%0d", c), busWord(),
                  expWord(c == 1, !(s && !v.wr), !(s && v.wr), v.mio, 1'b1,
                          c == 4 && !v.side_b, c == 4 && v.side_b, v.addr));
      if (v.wr && c >= 2) checkOutput($sformatf("wdata_T%0d", c), {24'b0, data_bus}, {24'b0, v.wdata});
    end
    setReq(v, 1'b0);
    tick();
    checkOutput("idle_after", busWord(), expWord(0, 1, 1, 0, 0, 0, 0, '0));
  endtask

  initial begin
    vec_t v;
    RESET = 1'b1; probe_en = 1'b0; probe_val = '0;
    req_a = 0; req_b = 0; wr_a = 0; wr_b = 0; mio_a = 0; mio_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

    //            side  wr    mio   addr        wdata  exp_rdata
    vecs[0] = '{1'b0, 1'b1, 1'b1, 20'h00123, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 20'h00123, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 20'h00040, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 20'h00040, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 20'h0003F, 8'h77, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 20'h0003F, 8'h11, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 20'h0003F, 8'h00, 8'h77};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 20'h0003F, 8'h00, 8'h11};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 20'hFFFFF, 8'hC3, 8'h00};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 20'hFFFFF, 8'h00, 8'hC3};

    tick();
    tick();
    checkOutput("reset_bus", busWord(), expWord(0, 1, 1, 0, 0, 0, 0, '0));
    checkOutput("reset_rdata", {24'b0, rdata}, 32'h0);
    RESET = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] simultaneous requests from reset");
    RESET = 1'b1;
    setReq(vecs[1], 1'b1);
    setReq(vecs[3], 1'b1);
    tick();
    RESET = 1'b0;
    for (int n = 0; n < (RR ? 2 : 3); n++) begin
      sb_q.push_back('{1'b0, 1'b1, 8'hA5});
      if (RR) sb_q.push_back('{1'b1, 1'b1, 8'h3C});
    end
    for (int c = 1; c <= (RR ? 16 : 14); c++) begin
      tick();
      checkOutput($sformatf("sim_ack_c%0d", c), {30'b0, ack_a, ack_b},
                  RR ? {30'b0, c % 8 == 4, c % 8 == 0} : {30'b0, c % 5 == 4, 1'b0});
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    checkOutput("sim_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] same requester repeat");
    setReq(vecs[1], 1'b1);
    sb_q.push_back('{1'b0, 1'b1, 8'hA5});
    sb_q.push_back('{1'b0, 1'b1, 8'hA5});
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 4 || c == 9) checkOutput($sformatf("rep_ack_c%0d", c), {31'b0, ack_a}, 32'd1);
      if (c == 5) checkOutput("rep_idle_gap", {31'b0, sys_bus.BUSY}, 32'd0);
      if (c == 6) checkOutput("rep_new_t1", {31'b0, sys_bus.ALE}, 32'd1);
    end
    req_a = 1'b0;
    tick();
    checkOutput("rep_sb_empty", sb_q.size(), 32'd0);

    $display("[TB] reset during T3 of a write");
    v = '{1'b0, 1'b1, 1'b1, 20'h00040, 8'h99, 8'h00};
    setReq(v, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("abort_t3_wr", {31'b0, sys_bus.WR_N}, 32'd0);
    RESET = 1'b1;
    req_a = 1'b0;
    tick();
    checkOutput("abort_bus", busWord(), expWord(0, 1, 1, 0, 0, 0, 0, '0));
    probe_val = 8'hE7;
    probe_en  = 1'b1;
    #1;
    checkOutput("abort_data_released", {24'b0, data_bus}, 32'hE7);
    probe_en = 1'b0;
    checkOutput("abort_mem_unchanged", {24'b0, mem_m[8'h40]}, 32'h3C);
    RESET = 1'b0;
    tick();
    checkOutput("abort_sb_empty", sb_q.size(), 32'd0);
    applyStimulus(v);
    applyStimulus('{1'b0, 1'b0, 1'b1, 20'h00040, 8'h00, 8'h99});
    checkOutput("final_sb_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_cycle_arbiter.md
# bus_cycle_arbiter

Two-requester bus master for the 8088-compatible system bus. It arbitrates between requester A (CPU-side port) and requester B (DMA/test port) and runs complete four-state bus cycles (T1–T4) on ALE/RD_N/WR_N/ADDRESS/DATA. These cycles are timed so that the team's memory and I/O slave modules latch the address, then read or write, with no wait states. Address decode to slave CS is external; this block provides M_IO for the decoder.

## Interface
Parameters:
- ADDR_WIDTH, 20, width of ADDRESS and requester addresses
- DATA_WIDTH, 8, width of DATA, WDATA_x, RDATA

Ports:
- CLK  in  1  bus clock, all logic on rising edge
- RESET  in  1  synchronous, active-high
- REQ_A / REQ_B  in  1  transfer request, held until the matching ACK
- WR_A / WR_B  in  1  1 = write, 0 = read; stable while REQ is high
- MIO_A / MIO_B  in  1  1 = memory, 0 = I/O; stable while REQ is high
- ADDR_A / ADDR_B  in  ADDR_WIDTH  transfer address; stable while REQ is high
- WDATA_A / WDATA_B  in  DATA_WIDTH  write data; stable while REQ is high
- ACK_A / ACK_B  out  1  one-cycle completion pulse
- RDATA  out  DATA_WIDTH  read data, valid in the ACK cycle of a read
- ALE  out  1  address latch enable, high in T1 only
- RD_N  out  1  read strobe, active low
- WR_N  out  1  write strobe, active low
- M_IO  out  1  memory/IO qualifier for the external decoder
- ADDRESS  out  ADDR_WIDTH  bus address, held T1–T4
- DATA  inout  DATA_WIDTH  bidirectional data bus
- BUSY  out  1  high in T1–T4

## Operation
- Moore FSM with states IDLE, T1, T2, T3, T4. All outputs are decoded from the state register and the latched transfer registers.
- IDLE: if any REQ is high, arbitrate. Latch the winner's WR, MIO, ADDR and WDATA into internal registers, record the owner, and go to T1. Otherwise stay in IDLE.
- T1 → T2 → T3 → T4 unconditionally. No wait states.
- T4: assert ACK of the owner. If the other requester's REQ is high, grant it, latch its request, and go to T1 (back-to-back). Otherwise go to IDLE. The owner's REQ is masked in T4. If the same requester still holds REQ after its ACK, that is a new request arbitrated from IDLE.
- Arbitration: round-robin. A last-served pointer grants the requester that was not served most recently when both request. The pointer is updated on every grant and resets to "B served", so A wins first.
- Strobes:
  - ALE = T1.
  - RD_N = 0 in T2 and T3 for reads.
  - WR_N = 0 in T2 and T3 for writes.
  - M_IO, ADDRESS driven from the latched registers in T1–T4; 0 in IDLE.
- DATA is driven with latched WDATA in T2, T3 and T4 of writes, and is high-Z otherwise. The block never drives DATA during reads.
- RDATA is captured from DATA on the rising edge ending T3 of a read and holds until the next read capture.

## Timing
- Slave alignment:
  - Slave samples CS && ALE at the end of T1 and loads the address during T2.
  - Slave samples RD_N/WR_N low at the end of T2.
  - A read slave drives DATA during T3; a write slave stores DATA at the end of T3.
  - The slave is idle again by the next T1.
- Latency: REQ first seen high in IDLE at edge k gives T1 in cycle k+1 and ACK in cycle k+4. Back-to-back cycles for alternating requesters have no idle cycle; the same requester repeating incurs one IDLE cycle.
- Bus utilisation with both requesters saturated: 4 cycles per transfer, alternating A, B, A, …
- Reset values: state IDLE, ALE 0, RD_N 1, WR_N 1, M_IO 0, ADDRESS 0, DATA high-Z, ACK_A/ACK_B 0, BUSY 0, RDATA 0, pointer as above.
- Reset mid-cycle: the cycle is aborted. From the next cycle, strobes are inactive and DATA is released. No ACK is issued, and the requester must re-request.
- REQ dropped before ACK is a protocol violation; the cycle completes regardless and the ACK is still pulsed.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration as above.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, A always wins simultaneous requests, and the pointer logic is removed. B can starve under continuous A traffic.

## Test plan
- Single read: REQ_A with ADDR_A=0x00123, WR_A=0, MIO_A=1, slave memory holding 0xA5 → ALE in T1, RD_N low T2–T3, ACK_A in cycle 4, RDATA=0xA5.
- Single write then read: B writes 0x3C to 0x00040, then B reads 0x00040 → WR_N low T2–T3, DATA=0x3C in T2–T4, read returns 0x3C.
- Simultaneous: REQ_A and REQ_B both high from reset → grant order A, B, A, B with no idle cycles and ACK every 4 cycles; with the macro undefined → A, A, … and no ACK_B while REQ_A is held.
- I/O cycle: REQ_A with MIO_A=0, addr 0x0003F → M_IO=0 throughout T1–T4 and the I/O slave is selected.
- Reset in T3 of a write → next cycle WR_N=1, DATA high-Z, no ACK, target location unchanged; re-request completes normally.
- Same-requester repeat: A holds REQ across its ACK → exactly one IDLE cycle, then a new T1 for A.
